fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequential fetch controller that owns the program counter and drives the combinational next-PC calculator. It issues instruction-memory reads with a req/ack handshake, presents each fetched instruction to decode with a valid/ready handshake, and loads the next-PC result when decode accepts. It also flags misaligned targets and counts retired instructions and memory stall cycles. It sits between the instruction memory and the decode/next-PC logic of the MIPS core.

## Interface
- RESET_PC, 32'h0000_3000: PC value loaded on reset; must be word-aligned.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction read request.
- imem_addr  out  32  read address; always equals pc.
- imem_ack  in  1  read complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- instr_valid  out  1  instr and pc are valid for decode.
- instr_ready  in  1  decode accepts the current instruction.
- pc  out  32  address of the current/pending instruction (fed to the next-PC calculator).
- npc  in  32  next-PC from the next-PC calculator; sampled only on accept.
- halt  in  1  decode marks the current instruction as the final one; sampled only on accept.
- halted  out  1  sequencer is stopped.
- misalign  out  1  sticky flag: a non-word-aligned npc was presented on accept.
- retire_cnt  out  32  number of accepted instructions.
- stall_cnt  out  32  cycles spent in REQ with imem_ack low.

## Operation
- States: REQ, VALID, HALTED. Reset state is REQ.
- **REQ**
  - imem_req=1 and instr_valid=0.
  - If imem_ack=1: instr <= imem_rdata and the state goes to VALID.
  - If imem_ack=0: stall_cnt increments and the state stays in REQ. The address is held stable until ack.
- **VALID**
  - imem_req=0 and instr_valid=1. instr and pc are held stable until accept.
  - Accept is instr_valid & instr_ready. On accept, retire_cnt increments. Then, in priority order:
    - halt=1: the state goes to HALTED and pc is unchanged. halt takes priority over a misaligned npc.
    - npc[1:0]!=0: misalign <= 1, the state goes to HALTED and pc is unchanged.
    - Otherwise: pc <= npc and the state goes to REQ.
- **HALTED**
  - imem_req=0, instr_valid=0, halted=1.
  - All inputs are ignored. Only reset leaves this state.
- imem_ack outside REQ is ignored; no capture and no counter change.
- instr_ready outside VALID is ignored.
- **Counters**
  - retire_cnt wraps from 32'hFFFF_FFFF to 0.
  - stall_cnt saturates at 32'hFFFF_FFFF.
- The sequencer performs no PC arithmetic. All redirect decisions (branch/j/jr) come in through npc.

## Timing
- **Reset values:** pc=RESET_PC, instr=0, instr_valid=0, imem_req=0 while rst is high. imem_req becomes 1 in the first cycle after rst deasserts, with the state in REQ. halted=0, misalign=0, retire_cnt=0, stall_cnt=0.
- **Reset mid-operation:** rst asserted in any state forces all outputs to reset values immediately (asynchronously). An outstanding imem request is abandoned. The memory must tolerate a dropped req.
- **Zero-wait memory:** ack in the same cycle as req gives instr_valid in the next cycle.
- **Accept timing:** with instr_ready held high, accept takes one cycle in VALID. imem_req for the new pc rises in the following cycle. Steady-state throughput is 1 instruction per 2 cycles. Each memory wait cycle adds 1 cycle.
- **npc sampling:** npc and halt are sampled at the accepting edge only. The value changes on those inputs at any other time have no effect.
- instr_valid, imem_req and halted are mutually exclusive and registered (state-decoded, no combinational path from inputs).

## Test plan
- **Reset and sequential fetch:** release rst, hold imem_ack=1, instr_ready=1, npc=pc+4 → imem_addr sequence 0x3000, 0x3004, 0x3008 on alternate cycles. retire_cnt=3 after the third accept. stall_cnt=0.
- **Memory wait states:** ack delayed 3 cycles on the first fetch → imem_addr held at 0x3000 for 4 cycles. instr_valid rises 1 cycle after ack. stall_cnt=3.
- **Decode backpressure and redirect:** instr_ready=0 for 5 cycles in VALID with npc=0x3040 → instr and pc stable, no imem_req. After ready=1, next imem_addr=0x3040. retire_cnt increments once.
- **Halt and misalignment:**
  - halt=1 on accept → halted=1, pc unchanged, retire_cnt incremented. Later acks and readies cause no change.
  - Separately after reset, npc=0x3006 on accept → misalign=1, halted=1, pc=0x3000.
- **Reset mid-wait:** assert rst while in REQ with ack low → imem_req=0 the same cycle. After release, pc=0x3000 and all counters are 0.
- **Counter boundaries:** force retire_cnt=32'hFFFF_FFFF and accept once → 0. Force stall_cnt=32'hFFFF_FFFF plus a 2-cycle stall → remains 32'hFFFF_FFFF.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches over a req/ack port, hands
// each word to decode over valid/ready and loads the next-PC result on accept.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    input  logic [31:0] npc,
    input  logic        halt,
    output logic        halted,
    output logic        misalign,
    output logic [31:0] retire_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_VALID  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        vld_q;
    logic        halted_q;
    logic        misalign_q;
    logic [31:0] retire_q;
    logic [31:0] retire_d;
    logic [31:0] stall_q;
    logic [31:0] stall_d;

    // retire_cnt wraps naturally; stall_cnt sticks at all-ones.
    assign retire_d = retire_q + 32'd1;
    assign stall_d  = (stall_q == 32'hFFFF_FFFF) ? stall_q : stall_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            req_q      <= 1'b1;
            vld_q      <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            retire_q   <= 32'd0;
            stall_q    <= 32'd0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= S_VALID;
                        req_q   <= 1'b0;
                        vld_q   <= 1'b1;
                    end else begin
                        stall_q <= stall_d;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        retire_q <= retire_d;
                        vld_q    <= 1'b0;
                        // halt outranks a bad target; both stop with pc unchanged
                        if (halt) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                        end else if (npc[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                            state_q    <= S_HALTED;
                            halted_q   <= 1'b1;
                        end else begin
                            pc_q    <= npc;
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q  <= S_HALTED;
                    req_q    <= 1'b0;
                    vld_q    <= 1'b0;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    // req_q comes out of reset set so the first fetch issues right after release;
    // masking with rst keeps the port quiet while reset is held.
    assign imem_req    = req_q & ~rst;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign misalign    = misalign_q;
    assign retire_cnt  = retire_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios push expected fetch
// addresses and decode words; a negedge monitor pops them on each handshake.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        halt = 1'b0;
    logic        halted;
    logic        misalign;
    logic [31:0] retire_cnt;
    logic [31:0] stall_cnt;

    logic        npc_sel = 1'b0;
    logic [31:0] npc_fix = 32'd0;

    int errs = 0;
    int chks = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } dec_t;

    logic [31:0] exp_fetch_q[$];
    dec_t        exp_dec_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h8C5A_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign npc        = npc_sel ? npc_fix : pc + 32'd4;

    fetch_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .npc(npc), .halt(halt),
        .halted(halted), .misalign(misalign),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        dec_t d;
        d.word = mem_word(a);
        d.addr = a;
        exp_fetch_q.push_back(a);
        exp_dec_q.push_back(d);
    endtask

    // Monitor: compares every completed handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req && imem_ack) begin
                if (exp_fetch_q.size() == 0) begin
                    chks++; errs++;
                    $display("FAIL fetch_unexpected: addr %h, none expected", imem_addr);
                end else begin
                    check("fetch_addr", imem_addr, exp_fetch_q.pop_front());
                end
            end
            if (instr_valid && instr_ready) begin
                if (exp_dec_q.size() == 0) begin
                    chks++; errs++;
                    $display("FAIL accept_unexpected: pc %h, none expected", pc);
                end else begin
                    dec_t d;
                    d = exp_dec_q.pop_front();
                    check("accept_instr", instr, d.word);
                    check("accept_pc", pc, d.addr);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        step();
        rst = 1'b1;
        #2;
        check("sb_fetch_drained", 32'(exp_fetch_q.size()), 32'd0);
        check("sb_dec_drained", 32'(exp_dec_q.size()), 32'd0);
        exp_fetch_q.delete();
        exp_dec_q.delete();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_pc", pc, 32'h3000);
        check("rst_instr", instr, 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        imem_ack = 1'b0; instr_ready = 1'b0; halt = 1'b0; npc_sel = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Sequential fetch, zero-wait memory, decode always ready
        do_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        push(32'h3000); push(32'h3004); push(32'h3008);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("seq_req", {31'd0, imem_req}, {31'd0, (i % 2) == 0});
            check("seq_valid", {31'd0, instr_valid}, {31'd0, (i % 2) == 1});
            check("seq_addr", imem_addr, 32'h3000 + 32'(4 * (i / 2)));
        end
        step();
        imem_ack = 1'b0; instr_ready = 1'b0;
        check("seq_retire", retire_cnt, 32'd3);
        check("seq_stall", stall_cnt, 32'd0);
        check("seq_pc", pc, 32'h300C);

        // Three wait states on the first fetch
        do_reset();
        exp_fetch_q.push_back(32'h3000);
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 3);
            @(negedge clk);
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h3000);
            step();
        end
        imem_ack = 1'b0;
        check("wait_valid", {31'd0, instr_valid}, 32'd1);
        check("wait_stall", stall_cnt, 32'd3);
        check("wait_instr", instr, mem_word(32'h3000));

        // Backpressure with a changing npc, then redirect to 0x3040
        npc_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            npc_fix = 32'h3006 + 32'(i * 8);
            @(negedge clk);
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_req", {31'd0, imem_req}, 32'd0);
            check("bp_instr", instr, mem_word(32'h3000));
            check("bp_pc", pc, 32'h3000);
            step();
        end
        npc_fix = 32'h3040; instr_ready = 1'b1;
        exp_dec_q.push_back('{word: mem_word(32'h3000), addr: 32'h3000});
        push(32'h3040);
        step();
        instr_ready = 1'b0; imem_ack = 1'b1; npc_fix = 32'h3001;
        check("redir_retire", retire_cnt, 32'd1);
        check("redir_pc", pc, 32'h3040);
        check("redir_req", {31'd0, imem_req}, 32'd1);
        check("redir_misalign", {31'd0, misalign}, 32'd0);
        step();
        imem_ack = 1'b0;
        check("redir_valid", {31'd0, instr_valid}, 32'd1);
        check("redir_instr", instr, mem_word(32'h3040));

        // Halt on accept, then everything is ignored
        halt = 1'b1; instr_ready = 1'b1; npc_fix = 32'h3080;
        step();
        halt = 1'b0;
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_pc", pc, 32'h3040);
        check("halt_retire", retire_cnt, 32'd2);
        check("halt_valid_req", {30'd0, instr_valid, imem_req}, 32'd0);
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            halt = i[0];
            step();
        end
        check("halted_hold", {31'd0, halted}, 32'd1);
        check("halted_pc", pc, 32'h3040);
        check("halted_retire", retire_cnt, 32'd2);
        check("halted_stall", stall_cnt, 32'd3);
        check("halted_instr", instr, mem_word(32'h3040));
        check("halted_misalign", {31'd0, misalign}, 32'd0);

        // Misaligned npc on accept
        do_reset();
        imem_ack = 1'b1; instr_ready = 1'b1; npc_sel = 1'b1; npc_fix = 32'h3006;
        push(32'h3000);
        step(); step();
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_halted", {31'd0, halted}, 32'd1);
        check("mis_pc", pc, 32'h3000);
        check("mis_retire", retire_cnt, 32'd1);

        // halt outranks a misaligned npc
        do_reset();
        imem_ack = 1'b1; instr_ready = 1'b1; npc_sel = 1'b1; npc_fix = 32'h3006; halt = 1'b1;
        push(32'h3000);
        step(); step();
        halt = 1'b0;
        check("prio_halted", {31'd0, halted}, 32'd1);
        check("prio_misalign", {31'd0, misalign}, 32'd0);

        // Reset while waiting on memory
        do_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        push(32'h3000);
        step(); step();
        imem_ack = 1'b0; instr_ready = 1'b0;
        check("mid_pc_pre", pc, 32'h3004);
        step(); step();
        check("mid_stall_pre", stall_cnt, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_req", {31'd0, imem_req}, 32'd0);
        check("mid_pc", pc, 32'h3000);
        check("mid_stall", stall_cnt, 32'd0);
        check("mid_retire", retire_cnt, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("mid_req_rel", {31'd0, imem_req}, 32'd1);
        check("mid_pc_rel", pc, 32'h3000);

        // Counter boundaries
        do_reset();
        imem_ack = 1'b1;
        exp_fetch_q.push_back(32'h3000);
        step();
        imem_ack = 1'b0;
        check("cnt_valid", {31'd0, instr_valid}, 32'd1);
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        #1;
        check("cnt_retire_forced", retire_cnt, 32'hFFFF_FFFF);
        instr_ready = 1'b1;
        exp_dec_q.push_back('{word: mem_word(32'h3000), addr: 32'h3000});
        step();
        instr_ready = 1'b0;
        check("cnt_retire_wrap", retire_cnt, 32'd0);
        check("cnt_pc", pc, 32'h3004);
        force dut.stall_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_q;
        #1;
        check("cnt_stall_forced", stall_cnt, 32'hFFFF_FFFF);
        step(); step();
        check("cnt_stall_sat", stall_cnt, 32'hFFFF_FFFF);
        check("cnt_req", {31'd0, imem_req}, 32'd1);

        check("sb_fetch_end", 32'(exp_fetch_q.size()), 32'd0);
        check("sb_dec_end", 32'(exp_dec_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
